psum_relu_quant_pack: RTL

PSUM_RELU_QUANT_PACK -- requirements
Module: psum_relu_quant_pack

---
 rtl/psum_relu_quant_pack.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/psum_relu_quant_pack.sv
// psum_relu_quant_pack
//   Takes a stream of signed 21-bit accumulated partial sums, applies a
//   per-layer bias, round-half-up requantization shift, optional ReLU and
//   int8 saturation, then packs BATCHES consecutive bytes into one output
//   SRAM word written at base_addr + words_written.
//
// Ports
//   clock, reset          : single clock, async active-high reset
//   start                 : one-cycle pulse, latches config and begins a layer
//   base_addr, num_words  : first word address / word count (sampled on start)
//   bias, shift, relu_en  : requantization config (sampled on start)
//   data_in, data_in_valid: psum stream, no backpressure
//   sram_wen/addr/wdata   : output SRAM write port
//   busy                  : layer in progress
//   done                  : one-cycle layer-complete pulse
module psum_relu_quant_pack #(
  parameter int BATCHES = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    num_words,
  input  logic [15:0]          bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  input  logic [20:0]          data_in,
  input  logic                 data_in_valid,
  output logic                 sram_wen,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [8*BATCHES-1:0] sram_wdata,
  output logic                 busy,
  output logic                 done
);
  localparam int LANE_W = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BATCHES - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q, num_q;
  logic [15:0]       bias_q;
  logic [4:0]        shift_q;
  logic              relu_q;

  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] grp_cnt;        // groups fully accepted
  logic [ADDR_W-1:0] words_written;

  logic              s1_vld, s1_last;
  logic [LANE_W-1:0] s1_lane;
  logic [7:0]        s1_byte;

  logic [BATCHES-1:0][7:0] acc, word;

  logic        start_idle, accept, fin;
  logic [4:0]  sh;
  logic signed [22:0] sum, rnd, r;
  logic [7:0]  qbyte;

  assign start_idle = (state == IDLE) && start;
  // once all requested groups are in, further samples are dropped
  assign accept     = (state == RUN) && data_in_valid && (grp_cnt != num_q);
  // words_written already counts the write being strobed this cycle
  assign fin        = sram_wen && (words_written == num_q);
  assign busy       = (state == RUN);

  // requantize: one spare bit above the 22-bit sum keeps the rounding add
  // from wrapping at the largest shift
  always_comb begin
    sh  = (shift_q > 5'd21) ? 5'd21 : shift_q;
    sum = {{2{data_in[20]}}, data_in} + {{7{bias_q[15]}}, bias_q};
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    r = (sum + rnd) >>> sh;
    if (relu_q && r < 0) r = '0;
    if (r > 23'sd127)       qbyte = 8'h7F;
    else if (r < -23'sd128) qbyte = 8'h80;
    else                    qbyte = r[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && num_words != '0) state_nxt = RUN;
      RUN:     if (fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // config latch and input-side counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      num_q   <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      lane    <= '0;
      grp_cnt <= '0;
    end else if (start_idle) begin
      base_q  <= base_addr;
      num_q   <= num_words;
      bias_q  <= bias;
      shift_q <= shift;
      relu_q  <= relu_en;
      lane    <= '0;
      grp_cnt <= '0;
    end else if (accept) begin
      lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
      if (lane == LAST_LANE) grp_cnt <= grp_cnt + ADDR_W'(1);
    end
  end

  // stage 1: registered quantized byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_lane <= '0;
      s1_byte <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_byte <= qbyte;
        s1_lane <= lane;
        s1_last <= (lane == LAST_LANE);
      end
    end
  end

  // the closing byte bypasses acc so the word is written without a gap
  always_comb begin
    word          = acc;
    word[s1_lane] = s1_byte;
  end

  // stage 2: pack and write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      sram_wen      <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      words_written <= '0;
      done          <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      done     <= (start_idle && num_words == '0) || fin;
      if (start_idle) words_written <= '0;
      if (s1_vld) begin
        acc[s1_lane] <= s1_byte;
        if (s1_last) begin
          sram_wen      <= 1'b1;
          sram_wdata    <= word;
          sram_addr     <= base_q + words_written;
          words_written <= words_written + ADDR_W'(1);
        end
      end
    end
  end
endmodule
